// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller:
// sequencing states, forwarding selects and the x0 register id.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_M  = 2'd1,
        FWD_W  = 2'd2
    } fwd_sel_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_fwd_unit.sv
// Forwarding compare for one E-stage operand.
// M-stage results win over W-stage results; x0 never forwards.
module pipe_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_M,
    input  logic       reg_wr_M,
    input  logic [4:0] rd_W,
    input  logic       reg_wr_W,
    output fwd_sel_t   sel
);

    // Pick the youngest in-flight producer of rs.
    always_comb begin
        sel = FWD_RF;
        if (reg_wr_M && rd_M != REG_ZERO && rd_M == rs) begin
            sel = FWD_M;
        end else if (reg_wr_W && rd_W != REG_ZERO && rd_W == rs) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard / sequencing controller for the 5-stage RV32 pipeline.
// Optional HAZARD_PERF_CNT_EN adds stall, redirect and load-use counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1_D,
    input  logic [4:0]  rs2_D,
    input  logic        rs1_used_D,
    input  logic        rs2_used_D,
    input  logic [4:0]  rs1_E,
    input  logic [4:0]  rs2_E,
    input  logic [4:0]  rd_E,
    input  logic        reg_wr_E,
    input  logic        mem_rd_E,
    input  logic [4:0]  rd_M,
    input  logic        reg_wr_M,
    input  logic [4:0]  rd_W,
    input  logic        reg_wr_W,
    input  logic        br_taken_E,
    input  logic        dmem_req_M,
    input  logic        dmem_ready,
    output logic        stall_F,
    output logic        stall_D,
    output logic        stall_E,
    output logic        stall_M,
    output logic        flush_D,
    output logic        flush_E,
    output logic [1:0]  fwd_a_E,
    output logic [1:0]  fwd_b_E,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flushes,
    output logic [31:0] perf_loaduse,
`endif
    output logic        mem_timeout
);

    hz_state_t        state;
    hz_state_t        state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;

    logic     mem_busy;
    logic     load_use;
    logic     stall_all;
    logic     stall_fd;
    logic     flush_d;
    logic     flush_e;
    logic     to_set;
    logic     lu_evt;
    fwd_sel_t sel_a;
    fwd_sel_t sel_b;

    pipe_fwd_unit u_fwd_a (
        .rs       (rs1_E),
        .rd_M     (rd_M),
        .reg_wr_M (reg_wr_M),
        .rd_W     (rd_W),
        .reg_wr_W (reg_wr_W),
        .sel      (sel_a)
    );

    pipe_fwd_unit u_fwd_b (
        .rs       (rs2_E),
        .rd_M     (rd_M),
        .reg_wr_M (reg_wr_M),
        .rd_W     (rd_W),
        .reg_wr_W (reg_wr_W),
        .sel      (sel_b)
    );

    assign mem_busy = dmem_req_M && !dmem_ready;

    assign load_use = mem_rd_E && reg_wr_E && rd_E != REG_ZERO &&
                      ((rs1_used_D && rs1_D == rd_E) ||
                       (rs2_used_D && rs2_D == rd_E));

    // Next-state and raw control decode; outputs are gated by reset below.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        stall_all = 1'b0;
        stall_fd  = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        to_set    = 1'b0;
        lu_evt    = 1'b0;
        unique case (state)
            RUN: begin
                if (mem_busy) begin
                    stall_all = 1'b1;
                    state_n   = MEM_WAIT;
                    cnt_n     = CNT_W'(1);
                end else if (br_taken_E) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (load_use) begin
                    stall_fd = 1'b1;
                    flush_e  = 1'b1;
                    lu_evt   = 1'b1;
                    state_n  = LOAD_STALL;
                end
            end
            LOAD_STALL: begin
                state_n = RUN;
                if (mem_busy) begin
                    stall_all = 1'b1;
                    state_n   = MEM_WAIT;
                    cnt_n     = CNT_W'(1);
                end else if (br_taken_E) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_n = RUN;
                    cnt_n   = '0;
                    if (br_taken_E) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end else if (cnt == CNT_W'(MEM_TIMEOUT)) begin
                    to_set  = 1'b1;
                    flush_e = 1'b1;
                    state_n = RUN;
                    cnt_n   = '0;
                end else begin
                    stall_all = 1'b1;
                    cnt_n     = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = RUN;
                cnt_n   = '0;
            end
        endcase
    end

    assign stall_F = reset && (stall_all || stall_fd);
    assign stall_D = reset && (stall_all || stall_fd);
    assign stall_E = reset && stall_all;
    assign stall_M = reset && stall_all;
    assign flush_D = reset && flush_d;
    assign flush_E = reset && flush_e;
    assign fwd_a_E = reset ? sel_a : FWD_RF;
    assign fwd_b_E = reset ? sel_b : FWD_RF;

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            cnt         <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            mem_timeout <= mem_timeout || to_set;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Free-running wrap-around event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
            perf_loaduse      <= '0;
        end else begin
            if (stall_F) perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (flush_D) perf_flushes      <= perf_flushes + 32'd1;
            if (lu_evt)  perf_loaduse      <= perf_loaduse + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
// Output vector: {sF,sD,sE,sM,fD,fE,fwd_a,fwd_b,timeout}.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic       rs1_used_D, rs2_used_D, reg_wr_E, mem_rd_E;
    logic       reg_wr_M, reg_wr_W, br_taken_E, dmem_req_M, dmem_ready;
    logic       stall_F, stall_D, stall_E, stall_M, flush_D, flush_E;
    logic [1:0] fwd_a_E, fwd_b_E;
    logic       mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_flushes, perf_loaduse;
`endif

    int passed = 0;
    int total  = 0;
    logic [10:0] exp_q[$];

    localparam logic [10:0] Z   = 11'b0;
    localparam logic [10:0] TO  = 11'b1;
    localparam logic [10:0] LU  = {6'b110001, 5'b0};
    localparam logic [10:0] ST4 = {6'b111100, 5'b0};
    localparam logic [10:0] RED = {6'b000011, 5'b0};
    localparam logic [10:0] TOF = {6'b000001, 5'b0};

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .rs1_D      (rs1_D),
        .rs2_D      (rs2_D),
        .rs1_used_D (rs1_used_D),
        .rs2_used_D (rs2_used_D),
        .rs1_E      (rs1_E),
        .rs2_E      (rs2_E),
        .rd_E       (rd_E),
        .reg_wr_E   (reg_wr_E),
        .mem_rd_E   (mem_rd_E),
        .rd_M       (rd_M),
        .reg_wr_M   (reg_wr_M),
        .rd_W       (rd_W),
        .reg_wr_W   (reg_wr_W),
        .br_taken_E (br_taken_E),
        .dmem_req_M (dmem_req_M),
        .dmem_ready (dmem_ready),
        .stall_F    (stall_F),
        .stall_D    (stall_D),
        .stall_E    (stall_E),
        .stall_M    (stall_M),
        .flush_D    (flush_D),
        .flush_E    (flush_E),
        .fwd_a_E    (fwd_a_E),
        .fwd_b_E    (fwd_b_E),
`ifdef HAZARD_PERF_CNT_EN
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flushes      (perf_flushes),
        .perf_loaduse      (perf_loaduse),
`endif
        .mem_timeout(mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] obs();
        return {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E,
                fwd_a_E, fwd_b_E, mem_timeout};
    endfunction

    function automatic logic [10:0] fw(input logic [1:0] a,
                                       input logic [1:0] b);
        return {6'b0, a, b, 1'b0};
    endfunction

    task automatic clr_in();
        rs1_D = 0; rs2_D = 0; rs1_used_D = 0; rs2_used_D = 0;
        rs1_E = 0; rs2_E = 0; rd_E = 0; reg_wr_E = 0; mem_rd_E = 0;
        rd_M = 0; reg_wr_M = 0; rd_W = 0; reg_wr_W = 0;
        br_taken_E = 0; dmem_req_M = 0; dmem_ready = 0;
    endtask

    task automatic set_lu();
        mem_rd_E = 1; reg_wr_E = 1; rd_E = 5'd5;
        rs1_D = 5'd5; rs1_used_D = 1;
    endtask

    task automatic test_reset();
        logic [10:0] g, e;
        reset = 0;
        clr_in();
        set_lu();
        dmem_req_M = 1;
        reg_wr_M = 1; rd_M = 5'd3; rs1_E = 5'd3;
        exp_q.push_back(Z);
        @(posedge clk); @(posedge clk); #1;
        g = obs(); e = exp_q.pop_front(); total++;
        if (g !== e) $display("FAIL reset got=%b exp=%b", g, e);
        else passed++;
        clr_in();
        reset = 1;
    endtask

    task automatic test_load_use();
        logic [10:0] g, e;
        for (int i = 0; i < 8; i++) begin
            clr_in();
            case (i)
                0: begin set_lu(); e = LU; end
                1: begin set_lu(); e = Z; end
                2: begin rd_W = 5'd5; reg_wr_W = 1; rs1_E = 5'd5;
                         e = fw(2'd2, 2'd0); end
                3: begin mem_rd_E = 1; reg_wr_E = 1; rd_E = 0;
                         rs1_D = 0; rs1_used_D = 1; e = Z; end
                4: begin mem_rd_E = 1; reg_wr_E = 1; rd_E = 5'd5;
                         rs1_D = 5'd3; rs1_used_D = 1;
                         rs2_D = 5'd5; e = Z; end
                5: begin mem_rd_E = 1; rd_E = 5'd5;
                         rs2_D = 5'd5; rs2_used_D = 1; e = Z; end
                6: begin mem_rd_E = 1; reg_wr_E = 1; rd_E = 5'd5;
                         rs2_D = 5'd5; rs2_used_D = 1; e = LU; end
                default: e = Z;
            endcase
            exp_q.push_back(e);
            #4;
            g = obs(); e = exp_q.pop_front(); total++;
            if (g !== e) $display("FAIL load_use[%0d] got=%b exp=%b", i, g, e);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fwd_priority();
        logic [10:0] g, e;
        for (int i = 0; i < 4; i++) begin
            clr_in();
            reg_wr_M = 1; reg_wr_W = 1;
            case (i)
                0: begin rd_M = 7; rd_W = 7; rs1_E = 7; rs2_E = 7;
                         e = fw(2'd1, 2'd1); end
                1: begin rd_M = 0; rd_W = 7; rs1_E = 7; rs2_E = 0;
                         e = fw(2'd2, 2'd0); end
                2: begin reg_wr_M = 0; rd_M = 7; rd_W = 7;
                         rs1_E = 7; rs2_E = 7; e = fw(2'd2, 2'd2); end
                default: begin rd_M = 9; rd_W = 0; rs1_E = 9; rs2_E = 0;
                         e = fw(2'd1, 2'd0); end
            endcase
            exp_q.push_back(e);
            #4;
            g = obs(); e = exp_q.pop_front(); total++;
            if (g !== e) $display("FAIL fwd[%0d] got=%b exp=%b", i, g, e);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_lu();
        logic [10:0] g, e;
        for (int i = 0; i < 10; i++) begin
            clr_in();
            case (i)
                0: begin set_lu(); br_taken_E = 1; e = RED; end
                1: begin set_lu(); e = LU; end
                2: begin set_lu(); e = Z; end
                3: begin set_lu(); e = LU; end
                4: begin set_lu(); br_taken_E = 1; e = RED; end
                5: e = Z;
                6: begin set_lu(); e = LU; end
                7: begin dmem_req_M = 1; e = ST4; end
                8: begin dmem_req_M = 1; dmem_ready = 1; e = Z; end
                default: e = Z;
            endcase
            exp_q.push_back(e);
            #4;
            g = obs(); e = exp_q.pop_front(); total++;
            if (g !== e) $display("FAIL branch[%0d] got=%b exp=%b", i, g, e);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        logic [10:0] g, e;
        for (int i = 0; i < 6; i++) begin
            clr_in();
            dmem_req_M = (i < 4);
            dmem_ready = (i == 3) || (i == 5);
            br_taken_E = (i < 4);
            e = (i < 3) ? ST4 : (i == 3) ? RED : Z;
            exp_q.push_back(e);
            #4;
            g = obs(); e = exp_q.pop_front(); total++;
            if (g !== e) $display("FAIL mem_wait[%0d] got=%b exp=%b", i, g, e);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        logic [10:0] g, e;
        for (int i = 0; i < 7; i++) begin
            clr_in();
            dmem_req_M = (i < 5);
            dmem_ready = (i == 6);
            e = (i < 4) ? ST4 : (i == 4) ? TOF : TO;
            exp_q.push_back(e);
            #4;
            g = obs(); e = exp_q.pop_front(); total++;
            if (g !== e) $display("FAIL timeout[%0d] got=%b exp=%b", i, g, e);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] g, e;
        for (int i = 0; i < 4; i++) begin
            clr_in();
            case (i)
                0: begin dmem_req_M = 1; e = ST4 | TO; end
                1: begin dmem_req_M = 1; e = ST4 | TO; end
                2: begin dmem_req_M = 1; set_lu(); br_taken_E = 1;
                         reg_wr_M = 1; rd_M = 5; rs1_E = 5;
                         #1 reset = 0; e = Z; end
                default: begin reset = 1; set_lu(); e = LU; end
            endcase
            exp_q.push_back(e);
            #3;
            g = obs(); e = exp_q.pop_front(); total++;
            if (g !== e) $display("FAIL reset_mid[%0d] got=%b exp=%b", i, g, e);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_fwd_priority();
        test_branch_lu();
        test_mem_wait();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
